// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU. Single-cycle arithmetic/logic ops, bit-serial
// shifts/rotates and an optional shift-add multiplier. Results and flags are
// registered and held until the next accepted operation.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (opcode 15);
// otherwise opcode 15 is treated as illegal and out_hi stays 0.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [3:0]       oper_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       flags_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags_out
);
  localparam int MSB = WIDTH-1;
  localparam int FZ = 0, FC = 1, FV = 2, FN = 3;
  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
                         OP_CMP = 4'd4,  OP_AND = 4'd5,  OP_ORR = 4'd6,  OP_XOR = 4'd7,
                         OP_INV = 4'd8,  OP_NEG = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11,
                         OP_ASR = 4'd12, OP_ROL = 4'd13, OP_ROR = 4'd14;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd15;
`endif
  // lsl/lsr run one extra step past WIDTH so C ends up 0 for huge shift counts
  localparam logic [WIDTH-1:0] LSH_MAX  = WIDTH'(WIDTH+1);
  localparam logic [WIDTH-1:0] ASR_MAX  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ROT_MASK = WIDTH'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_lo, r_hi_out;
  logic [3:0]       r_fl;
  logic [3:0]       r_op;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_acc, r_b;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_st_hi;
`endif

  logic             w_acc, w_cin, w_ovf, w_zn, w_iter;
  logic [WIDTH-1:0] w_bx, w_res, w_lo, w_st_lo;
  logic [WIDTH:0]   w_sum;
  logic [CNT_W-1:0] w_steps;
  logic [3:0]       w_fl, w_fin;
  logic             w_st_c;

  assign w_acc     = start_in && !r_busy;
  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign out_lo    = r_lo;
  assign out_hi    = r_hi_out;
  assign flags_out = r_fl;

  // Decode the incoming op: single-cycle result/flags, or iteration count
  always_comb begin
    w_bx  = b_in;
    w_cin = 1'b0;
    case (oper_in)
      OP_ADC:         w_cin = flags_in[FC];
      OP_SUB, OP_CMP: begin w_bx = ~b_in; w_cin = 1'b1; end
      OP_SBC:         begin w_bx = ~b_in; w_cin = flags_in[FC]; end
      default: ;
    endcase
    w_sum = {1'b0, a_in} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
    w_ovf = (a_in[MSB] == w_bx[MSB]) && (w_sum[MSB] != a_in[MSB]);

    w_res   = a_in;
    w_zn    = 1'b0;
    w_iter  = 1'b0;
    w_steps = '0;
    w_fl    = flags_in;
    case (oper_in)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        w_res     = w_sum[MSB:0];
        w_zn      = 1'b1;
        w_fl[FC]  = w_sum[WIDTH];
        w_fl[FV]  = w_ovf;
      end
      OP_AND: begin w_res = a_in & b_in; w_zn = 1'b1; end
      OP_ORR: begin w_res = a_in | b_in; w_zn = 1'b1; end
      OP_XOR: begin w_res = a_in ^ b_in; w_zn = 1'b1; end
      OP_INV: begin w_res = ~a_in;       w_zn = 1'b1; end
      OP_NEG: begin w_res = '0 - a_in;   w_zn = 1'b1; end
      OP_LSL, OP_LSR: if (b_in != '0) begin
        w_iter  = 1'b1;
        w_steps = (b_in > LSH_MAX) ? CNT_W'(LSH_MAX) : CNT_W'(b_in);
      end
      OP_ASR: if (b_in != '0) begin
        w_iter  = 1'b1;
        w_steps = (b_in > ASR_MAX) ? CNT_W'(ASR_MAX) : CNT_W'(b_in);
      end
      OP_ROL, OP_ROR: if (b_in != '0) begin
        // a whole number of turns finishes at once but still refreshes Z/N
        w_steps = CNT_W'(b_in & ROT_MASK);
        if (w_steps == '0) w_zn = 1'b1;
        else               w_iter = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin w_iter = 1'b1; w_steps = CNT_W'(WIDTH); end
`endif
      default: ;
    endcase
    w_lo = (oper_in == OP_CMP) ? r_lo : w_res;
    if (w_zn) begin
      w_fl[FZ] = (w_res == '0);
      w_fl[FN] = w_res[MSB];
    end
  end

  // One iteration step of the latched op, plus final flags for the last step
  always_comb begin
    w_st_lo = r_sh;
    w_st_c  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_madd  = '0;
    w_st_hi = r_acc;
`endif
    case (r_op)
      OP_LSL: begin w_st_lo = {r_sh[MSB-1:0], 1'b0};     w_st_c = r_sh[MSB]; end
      OP_LSR: begin w_st_lo = {1'b0, r_sh[MSB:1]};       w_st_c = r_sh[0];   end
      OP_ASR: begin w_st_lo = {r_sh[MSB], r_sh[MSB:1]};  w_st_c = r_sh[0];   end
      OP_ROL: w_st_lo = {r_sh[MSB-1:0], r_sh[MSB]};
      OP_ROR: w_st_lo = {r_sh[0], r_sh[MSB:1]};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        // accumulator in the high half, multiplier shifts out of the low half
        w_madd  = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_b} : '0);
        w_st_hi = w_madd[WIDTH:1];
        w_st_lo = {w_madd[0], r_sh[MSB:1]};
      end
`endif
      default: ;
    endcase
    w_fin     = r_flags;
    w_fin[FZ] = (w_st_lo == '0);
    w_fin[FN] = w_st_lo[MSB];
    if (r_op == OP_LSL || r_op == OP_LSR || r_op == OP_ASR) w_fin[FC] = w_st_c;
`ifdef ALU_SEQ_MUL_EN
    if (r_op == OP_MUL) begin
      w_fin[FZ] = ({w_st_hi, w_st_lo} == '0);
      w_fin[FN] = w_st_hi[MSB];
      w_fin[FC] = (w_st_hi != '0);
    end
`endif
  end

  // Control FSM with registered results; outputs change only with done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lo     <= '0;
      r_hi_out <= '0;
      r_fl     <= '0;
      r_op     <= '0;
      r_flags  <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_acc    <= '0;
      r_b      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_sh  <= w_st_lo;
          r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
          r_acc <= w_st_hi;
`endif
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_lo    <= w_st_lo;
            r_fl    <= w_fin;
`ifdef ALU_SEQ_MUL_EN
            r_hi_out <= (r_op == OP_MUL) ? w_st_hi : '0;
`else
            r_hi_out <= '0;
`endif
          end
        end
        default: begin
          if (w_acc) begin
            r_op    <= oper_in;
            r_flags <= flags_in;
            r_sh    <= a_in;
            r_cnt   <= w_steps;
`ifdef ALU_SEQ_MUL_EN
            r_acc   <= '0;
            r_b     <= b_in;
`endif
            if (w_iter) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_lo     <= w_lo;
              r_hi_out <= '0;
              r_fl     <= w_fl;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); expectations hand-computed.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst, start_in;
  logic [3:0] oper_in, flags_in, flags_out;
  logic [7:0] a_in, b_in, out_lo, out_hi;
  logic       busy_out, done_out;
  int n_chk = 0, n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .oper_in(oper_in),
    .a_in(a_in), .b_in(b_in), .flags_in(flags_in),
    .busy_out(busy_out), .done_out(done_out),
    .out_lo(out_lo), .out_hi(out_hi), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check results.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fl, input int elat,
                       input logic [7:0] elo, input logic [7:0] ehi, input logic [3:0] efl);
    int lat;
    logic seen;
    logic [7:0] prev_lo;
    @(negedge clk);
    start_in = 1'b1; oper_in = op; a_in = a; b_in = b; flags_in = fl;
    prev_lo = out_lo;
    @(posedge clk); #1;
    start_in = 1'b0; oper_in = 4'h7; a_in = 8'h5A; b_in = 8'h33; flags_in = ~fl;
    lat = 1;
    seen = done_out;
    if (!seen) begin
      chk({tag, ".busy"}, busy_out, 1'b1);
      chk({tag, ".hold"}, out_lo, prev_lo);
    end
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = done_out;
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".lo"}, out_lo, elo);
    chk({tag, ".hi"}, out_hi, ehi);
    chk({tag, ".fl"}, flags_out, efl);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start_in = 1'b0; oper_in = '0; a_in = '0; b_in = '0; flags_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy_out, 0);
    chk("rst.done", done_out, 0);
    chk("rst.lo", out_lo, 0);
    chk("rst.hi", out_hi, 0);
    chk("rst.fl", flags_out, 0);
    @(negedge clk); rst = 1'b0;

    // flags: [0]Z [1]C [2]V [3]N
    do_op("add",  4'd0,  8'hFF, 8'h01, 4'h0, 1,  8'h00, 8'h00, 4'b0011);
    @(posedge clk); #1;
    chk("add.pulse", done_out, 0);
    do_op("sub",  4'd2,  8'h80, 8'h01, 4'h0, 1,  8'h7F, 8'h00, 4'b0110);
    do_op("cmp",  4'd4,  8'h05, 8'h05, 4'h0, 1,  8'h7F, 8'h00, 4'b0011);
    do_op("adc",  4'd1,  8'h7F, 8'h00, 4'b0010, 1, 8'h80, 8'h00, 4'b1100);
    do_op("sbc",  4'd3,  8'h00, 8'h00, 4'h0, 1,  8'hFF, 8'h00, 4'b1000);
    do_op("and",  4'd5,  8'hF0, 8'h3C, 4'b0110, 1, 8'h30, 8'h00, 4'b0110);
    do_op("neg",  4'd9,  8'h01, 8'h00, 4'h0, 1,  8'hFF, 8'h00, 4'b1000);
    do_op("lsl1", 4'd10, 8'h81, 8'd1,   4'h0, 2,  8'h02, 8'h00, 4'b0010);
    do_op("lslbig", 4'd10, 8'h81, 8'd200, 4'h0, 10, 8'h00, 8'h00, 4'b0001);
    do_op("lsr8", 4'd11, 8'h81, 8'd8,   4'h0, 9,  8'h00, 8'h00, 4'b0011);
    do_op("asr",  4'd12, 8'h80, 8'd3,   4'h0, 4,  8'hF0, 8'h00, 4'b1000);
    do_op("ror9", 4'd14, 8'h01, 8'd9,   4'b0010, 2, 8'h80, 8'h00, 4'b1010);
    do_op("rol0", 4'd13, 8'h3C, 8'd0,   4'hF, 1,  8'h3C, 8'h00, 4'hF);
    do_op("rol8", 4'd13, 8'h81, 8'd8,   4'b1011, 1, 8'h81, 8'h00, 4'b1010);
`ifdef ALU_SEQ_MUL_EN
    do_op("mul",  4'd15, 8'hFF, 8'hFF, 4'b0100, 9, 8'h01, 8'hFE, 4'b1110);
`else
    do_op("mul",  4'd15, 8'hFF, 8'hFF, 4'b0100, 1, 8'hFF, 8'h00, 4'b0100);
`endif

    // reset in the 3rd RUN cycle of lsr b=6 aborts with no done
    @(negedge clk);
    start_in = 1'b1; oper_in = 4'd11; a_in = 8'hF0; b_in = 8'd6; flags_in = 4'h0;
    @(posedge clk); #1; start_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort.busy", busy_out, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy0", busy_out, 0);
    chk("abort.lo", out_lo, 0);
    chk("abort.hi", out_hi, 0);
    chk("abort.fl", flags_out, 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_out) dones++;
    end
    chk("abort.nodone", dones, 0);

    // start during RUN is ignored and not queued
    begin
      int lat;
      @(negedge clk);
      start_in = 1'b1; oper_in = 4'd10; a_in = 8'h81; b_in = 8'd4; flags_in = 4'h0;
      @(posedge clk); #1; start_in = 1'b0;
      @(negedge clk);
      start_in = 1'b1; oper_in = 4'd0; a_in = 8'h01; b_in = 8'h01;
      @(posedge clk); #1; start_in = 1'b0;
      lat = 2;
      while (!done_out && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("ign.lat", lat, 5);
      chk("ign.lo", out_lo, 8'h10);
      chk("ign.fl", flags_out, 4'b0000);
      @(posedge clk); #1;
      chk("ign.nodone", done_out, 0);
      chk("ign.busy", busy_out, 0);
    end

    // start held high: second op accepted in the DONE cycle
    @(negedge clk);
    start_in = 1'b1; oper_in = 4'd10; a_in = 8'h01; b_in = 8'd2; flags_in = 4'h0;
    @(posedge clk); #1;
    @(negedge clk);
    oper_in = 4'd0; a_in = 8'h02; b_in = 8'h03;
    @(posedge clk); #1;
    chk("b2b.run", done_out, 0);
    @(posedge clk); #1;
    chk("b2b.d1", done_out, 1);
    chk("b2b.lo1", out_lo, 8'h04);
    chk("b2b.busy", busy_out, 0);
    @(posedge clk); #1;
    chk("b2b.d2", done_out, 1);
    chk("b2b.lo2", out_lo, 8'h05);
    start_in = 1'b0;
    @(posedge clk); #1;
    chk("b2b.end", done_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
